// File: rtl/forward_tracker_pkg.sv
// ----------------------------------------------------------------------------
// forward_tracker_pkg
// Purpose : shared widths, constants and the in-flight slot record used by the
//           forwarding tracker, its slot-match sub-module and its interface.
// Contents: DATA_W / RADDR_W   register data and register address widths
//           ZERO_REG           hard-wired zero register (never forwarded)
//           slot_t             {valid, wr, load, dest} record of one
//                              in-flight instruction
//           SLOT_EMPTY         bubble / reset value of a slot
// ----------------------------------------------------------------------------
package forward_tracker_pkg;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;

    localparam logic [RADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic               valid;
        logic               wr;
        logic               load;
        logic [RADDR_W-1:0] dest;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/forward_tracker_if.sv
// ----------------------------------------------------------------------------
// forward_tracker_if
// Purpose : bundles every non-clock/reset signal of the forwarding tracker.
// Signals : hold                       pipeline freeze
//           ex_valid/ex_wr/ex_load/ex_dest  instruction entering slot One
//           one_result, load_data      data produced by the slot One instruction
//           src_a, src_b               decode-stage source registers
//           one_x_data, two_x_data     forwarding candidates (x = a, b)
//           one_x_sel, two_x_sel       mux select flags
//           stall                      load-use hazard
// Modports: master = pipeline side (drives inputs, consumes results)
//           slave  = forward_tracker
// ----------------------------------------------------------------------------
interface forward_tracker_if;
    import forward_tracker_pkg::*;

    logic               hold;
    logic               ex_valid;
    logic               ex_wr;
    logic               ex_load;
    logic [RADDR_W-1:0] ex_dest;
    logic [DATA_W-1:0]  one_result;
    logic [DATA_W-1:0]  load_data;
    logic [RADDR_W-1:0] src_a;
    logic [RADDR_W-1:0] src_b;
    logic [DATA_W-1:0]  one_a_data;
    logic [DATA_W-1:0]  one_b_data;
    logic [DATA_W-1:0]  two_a_data;
    logic [DATA_W-1:0]  two_b_data;
    logic               one_a_sel;
    logic               one_b_sel;
    logic               two_a_sel;
    logic               two_b_sel;
    logic               stall;

    modport master (
        output hold, ex_valid, ex_wr, ex_load, ex_dest,
               one_result, load_data, src_a, src_b,
        input  one_a_data, one_b_data, two_a_data, two_b_data,
               one_a_sel, one_b_sel, two_a_sel, two_b_sel, stall
    );

    modport slave (
        input  hold, ex_valid, ex_wr, ex_load, ex_dest,
               one_result, load_data, src_a, src_b,
        output one_a_data, one_b_data, two_a_data, two_b_data,
               one_a_sel, one_b_sel, two_a_sel, two_b_sel, stall
    );

endinterface

// File: rtl/fwd_slot_match.sv
// ----------------------------------------------------------------------------
// fwd_slot_match
// Purpose : decides whether one in-flight slot produces the value a decode
//           source register wants.
// Ports   : slot_i  in  slot_t   in-flight instruction record
//           src_i   in  RADDR_W  decode source register
//           hit_o   out 1        slot is a real register write to src_i
// ----------------------------------------------------------------------------
module fwd_slot_match
    import forward_tracker_pkg::*;
(
    input  slot_t              slot_i,
    input  logic [RADDR_W-1:0] src_i,
    output logic               hit_o
);

    // The zero register reads as constant zero, so a write to it is never
    // something the consumer should pick up.
    assign hit_o = slot_i.valid & slot_i.wr
                 & (slot_i.dest == src_i)
                 & (src_i != ZERO_REG);

    // Whether the producer is a load is the caller's business (stall vs.
    // forward), so that field is deliberately not looked at here.
    logic unused_load;
    assign unused_load = slot_i.load;

endmodule

// File: rtl/forward_tracker.sv
// ----------------------------------------------------------------------------
// forward_tracker
// Purpose : forwarding control stage in front of the forwarding data mux.
//           Tracks the two youngest in-flight register writes (slot One = one
//           stage ahead of the consumer, slot Two = two stages ahead), matches
//           them against the decode sources and raises a one-cycle load-use
//           stall when a load result is needed before memory returns it.
// Ports   : clk  in  rising-edge clock
//           rst  in  asynchronous, active-high reset
//           bus  forward_tracker_if.slave (see the interface for the signals)
// ----------------------------------------------------------------------------
module forward_tracker
    import forward_tracker_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    forward_tracker_if.slave  bus
);

    slot_t             one_q, one_d;
    slot_t             two_q, two_d;
    logic [DATA_W-1:0] data2_q, data2_d;

    logic hit1a, hit1b, hit2a, hit2b;
    logic stall;

    fwd_slot_match u_match_1a (.slot_i(one_q), .src_i(bus.src_a), .hit_o(hit1a));
    fwd_slot_match u_match_1b (.slot_i(one_q), .src_i(bus.src_b), .hit_o(hit1b));
    fwd_slot_match u_match_2a (.slot_i(two_q), .src_i(bus.src_a), .hit_o(hit2a));
    fwd_slot_match u_match_2b (.slot_i(two_q), .src_i(bus.src_b), .hit_o(hit2b));

    // A load in slot One has no data yet: stall instead of forwarding. Slot
    // Two always has its data, and the consumer resolves One-over-Two.
    assign stall         = (hit1a | hit1b) & one_q.load;
    assign bus.stall     = stall;
    assign bus.one_a_sel = hit1a & ~one_q.load;
    assign bus.one_b_sel = hit1b & ~one_q.load;
    assign bus.two_a_sel = hit2a;
    assign bus.two_b_sel = hit2b;

    assign bus.one_a_data = bus.one_result;
    assign bus.one_b_data = bus.one_result;
    assign bus.two_a_data = data2_q;
    assign bus.two_b_data = data2_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        one_d   = one_q;
        two_d   = two_q;
        data2_d = data2_q;
        if (!bus.hold) begin
            // Slot Two only needs {valid, wr, dest}; its data is captured
            // here, so the load flag is dropped.
            two_d   = '{valid: one_q.valid, wr: one_q.wr, load: 1'b0, dest: one_q.dest};
            data2_d = one_q.load ? bus.load_data : bus.one_result;
            // On a stall decode re-presents the same instruction next cycle,
            // so whatever is on ex_* now is replaced by a bubble.
            one_d   = stall ? SLOT_EMPTY
                            : '{valid: bus.ex_valid, wr: bus.ex_wr,
                                load: bus.ex_load, dest: bus.ex_dest};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            one_q   <= SLOT_EMPTY;
            two_q   <= SLOT_EMPTY;
            data2_q <= '0;
        end else begin
            one_q   <= one_d;
            two_q   <= two_d;
            data2_q <= data2_d;
        end
    end

endmodule

// File: tb/tb_forward_tracker.sv
// ----------------------------------------------------------------------------
// tb_forward_tracker
// Purpose : self-checking bench for forward_tracker. A table of per-cycle
//           stimulus with hand-computed outputs drives the main scenarios;
//           a hand-written sequence covers asynchronous reset mid-stall.
// ----------------------------------------------------------------------------
module tb_forward_tracker;
    import forward_tracker_pkg::*;

    logic clk;
    logic rst;

    forward_tracker_if bus ();

    forward_tracker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One record per clock cycle: inputs applied during the cycle and the
    // outputs expected before that cycle's closing edge.
    typedef struct packed {
        logic               hold;
        logic               ev;
        logic               ew;
        logic               el;
        logic [RADDR_W-1:0] dest;
        logic [DATA_W-1:0]  one_result;
        logic [DATA_W-1:0]  load_data;
        logic [RADDR_W-1:0] sa;
        logic [RADDR_W-1:0] sb;
        logic [3:0]         sel;      // {one_a, one_b, two_a, two_b}
        logic               stall;
        logic [DATA_W-1:0]  two_data;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input logic h, input logic ev, input logic ew, input logic el,
                         input logic [RADDR_W-1:0] dest, input logic [DATA_W-1:0] res,
                         input logic [DATA_W-1:0] ld, input logic [RADDR_W-1:0] sa,
                         input logic [RADDR_W-1:0] sb);
        bus.hold       = h;
        bus.ex_valid   = ev;
        bus.ex_wr      = ew;
        bus.ex_load    = el;
        bus.ex_dest    = dest;
        bus.one_result = res;
        bus.load_data  = ld;
        bus.src_a      = sa;
        bus.src_b      = sb;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] sel, input logic stall,
                                 input logic [DATA_W-1:0] one_data,
                                 input logic [DATA_W-1:0] two_data);
        check({tag, " one_a_sel"},  32'(bus.one_a_sel),  32'(sel[3]));
        check({tag, " one_b_sel"},  32'(bus.one_b_sel),  32'(sel[2]));
        check({tag, " two_a_sel"},  32'(bus.two_a_sel),  32'(sel[1]));
        check({tag, " two_b_sel"},  32'(bus.two_b_sel),  32'(sel[0]));
        check({tag, " stall"},      32'(bus.stall),      32'(stall));
        check({tag, " one_a_data"}, 32'(bus.one_a_data), 32'(one_data));
        check({tag, " one_b_data"}, 32'(bus.one_b_data), 32'(one_data));
        check({tag, " two_a_data"}, 32'(bus.two_a_data), 32'(two_data));
        check({tag, " two_b_data"}, 32'(bus.two_b_data), 32'(two_data));
    endtask

    initial begin
        //               hold ev ew el dest result    load_data sa sb  sel      stall two_data
        // ALU chain: r3 := 0x1234
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,3'd3,16'h0000,16'h0000,3'd0,3'd0,4'b0000,1'b0,16'h0000});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,3'd0,16'h1234,16'h0000,3'd3,3'd0,4'b1000,1'b0,16'h0000});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,16'h0000,3'd3,3'd0,4'b0010,1'b0,16'h1234});
        // Load-use: load r2 = 0xBEEF; the r6 issued during the stall is dropped
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,3'd2,16'h0000,16'h0000,3'd0,3'd0,4'b0000,1'b0,16'h0000});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,3'd6,16'h0000,16'hBEEF,3'd0,3'd2,4'b0000,1'b1,16'h0000});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,16'h0000,3'd6,3'd2,4'b0001,1'b0,16'hBEEF});
        // Register 0 is never forwarded
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,3'd0,16'h0000,16'h0000,3'd0,3'd0,4'b0000,1'b0,16'h0000});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,3'd0,16'h5555,16'h0000,3'd0,3'd0,4'b0000,1'b0,16'h0000});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,16'h0000,3'd0,3'd0,4'b0000,1'b0,16'h5555});
        // Double write to r5, src_a == src_b
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,3'd5,16'h0000,16'h0000,3'd0,3'd0,4'b0000,1'b0,16'h0000});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,3'd5,16'h0001,16'h0000,3'd0,3'd0,4'b0000,1'b0,16'h0000});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,3'd0,16'h0002,16'h0000,3'd5,3'd5,4'b1111,1'b0,16'h0001});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,16'h0000,3'd5,3'd5,4'b0011,1'b0,16'h0002});
        // ex_wr = 0 / ex_valid = 0 entries never match
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,3'd4,16'h0000,16'h0000,3'd0,3'd0,4'b0000,1'b0,16'h0000});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,3'd4,16'h0000,16'h0000,3'd4,3'd0,4'b0000,1'b0,16'h0000});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,16'h0000,3'd4,3'd4,4'b0000,1'b0,16'h0000});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,16'h0000,3'd4,3'd4,4'b0000,1'b0,16'h0000});
        // Hold with a load r7 in slot One; ex r3 offered throughout must be dropped
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,3'd7,16'h0000,16'h0000,3'd0,3'd0,4'b0000,1'b0,16'h0000});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,3'd3,16'h0000,16'h1111,3'd7,3'd0,4'b0000,1'b1,16'h0000});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,3'd3,16'h0000,16'h1111,3'd7,3'd0,4'b0000,1'b1,16'h0000});
        vecs.push_back('{1'b1,1'b1,1'b1,1'b0,3'd3,16'h0000,16'h1111,3'd7,3'd0,4'b0000,1'b1,16'h0000});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,3'd3,16'h0000,16'hCAFE,3'd7,3'd0,4'b0000,1'b1,16'h0000});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,3'd0,16'h0000,16'h0000,3'd7,3'd3,4'b0010,1'b0,16'hCAFE});

        // Reset state
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 4'b0000, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b0;

        // Table-driven cycles
        foreach (vecs[i]) begin
            drive(vecs[i].hold, vecs[i].ev, vecs[i].ew, vecs[i].el, vecs[i].dest,
                  vecs[i].one_result, vecs[i].load_data, vecs[i].sa, vecs[i].sb);
            @(negedge clk);
            check_outputs($sformatf("row%0d", i), vecs[i].sel, vecs[i].stall,
                          vecs[i].one_result, vecs[i].two_data);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-stall: ALU r1 (0x7777) in Two, load r2 in One
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 16'h0000, 16'h0000, 3'd0, 3'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 16'h7777, 16'h0000, 3'd0, 3'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd2, 3'd1);
        #2;
        check_outputs("pre_rst", 4'b0001, 1'b1, 16'h0000, 16'h7777);
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 4'b0000, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_outputs("post_rst", 4'b0000, 1'b0, 16'h0000, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
